// File: rtl/fp_max_tracker.sv
// Tracks the largest IEEE-754 single of each N-beat frame, its index, positive-nonzero count and OR of overflow.
// Optional FP_MAX_TRACKER_RELU_EN: negative beats are clamped to +0 before comparison.
module fp_max_tracker #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   in_data,
    input  logic          in_ovf,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   max_val,
    output logic [IW-1:0] max_idx,
    output logic [IW:0]   active_cnt,
    output logic          ovf,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned CW = IW + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_in_ready;
    logic [31:0]   r_max_val;
    logic [IW-1:0] r_max_idx;
    logic [CW-1:0] r_active_cnt;
    logic          r_ovf;
    logic          r_out_valid;
    logic [CW-1:0] r_beat_cnt;

    logic [31:0]   w_data;
    logic          w_accept;
    logic          w_active;
    logic          w_wins;

    // True when a strictly beats b; +0 and -0 are equal, NaNs compare as raw bits.
    function automatic logic f_beats(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
        if (a[31] != b[31]) return ~a[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

`ifdef FP_MAX_TRACKER_RELU_EN
    assign w_data = in_data[31] ? 32'd0 : in_data;
`else
    assign w_data = in_data;
`endif

    assign w_accept = in_valid & r_in_ready;
    assign w_active = ~w_data[31] & (w_data[30:0] != 31'd0);
    assign w_wins   = f_beats(w_data, r_max_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_max_val    <= 32'd0;
            r_max_idx    <= '0;
            r_active_cnt <= '0;
            r_ovf        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_max_val    <= w_data;
                        r_max_idx    <= '0;
                        r_active_cnt <= CW'(w_active);
                        r_ovf        <= in_ovf;
                        r_beat_cnt   <= CW'(1);
                        r_state      <= ACC;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        // Ties keep the stored entry so the earliest index wins.
                        if (w_wins) begin
                            r_max_val <= w_data;
                            r_max_idx <= r_beat_cnt[IW-1:0];
                        end
                        if (w_active && (r_active_cnt != CNT_SAT))
                            r_active_cnt <= r_active_cnt + CW'(1);
                        r_ovf      <= r_ovf | in_ovf;
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign max_val    = r_max_val;
    assign max_idx    = r_max_idx;
    assign active_cnt = r_active_cnt;
    assign ovf        = r_ovf;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_fp_max_tracker.sv
// Scoreboard bench for fp_max_tracker (N=4): driver pushes expected frame results, monitor pops on out_valid rise.
module tb_fp_max_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_ovf;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] max_val;
    logic [1:0]  max_idx;
    logic [2:0]  active_cnt;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    typedef struct packed {
        logic [31:0] val;
        logic [1:0]  idx;
        logic [2:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_prev = 1'b0;

    fp_max_tracker #(.N(4), .IW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_ovf     (in_ovf),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .max_val    (max_val),
        .max_idx    (max_idx),
        .active_cnt (active_cnt),
        .ovf        (ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endfunction

    // Monitor: compare each newly presented result against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1 && mon_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_max_val", max_val, e.val);
                chk("sb_max_idx", 32'(max_idx), 32'(e.idx));
                chk("sb_active_cnt", 32'(active_cnt), 32'(e.cnt));
                chk("sb_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
        mon_prev = out_valid;
    end

    task automatic send_beat(input logic [31:0] d, input logic o);
        @(negedge clk);
        chk("in_ready_before_beat", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ovf   = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3,
                             input logic [3:0] ovfs, input exp_t e,
                             input int gap, input int hold);
        logic [31:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            send_beat(beats[i], ovfs[i]);
            if (i < 3) begin
                chk("no_early_valid", 32'(out_valid), 32'd0);
                repeat (gap) @(posedge clk);
            end
        end
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_max_val", max_val, e.val);
            chk("hold_max_idx", 32'(max_idx), 32'(e.idx));
            chk("hold_ovf", 32'(ovf), 32'(e.ovf));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b1; in_data = 32'd0; in_ovf = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_max_val", max_val, 32'd0);
        chk("rst_max_idx", 32'(max_idx), 32'd0);
        chk("rst_active_cnt", 32'(active_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic positive frame.
        e = '{val: 32'h40400000, idx: 2'd1, cnt: 3'd4, ovf: 1'b0};
        run_frame(32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000, 4'b0000, e, 0, 0);

        // All-negative frame, ends in -0.
`ifdef FP_MAX_TRACKER_RELU_EN
        e = '{val: 32'h00000000, idx: 2'd0, cnt: 3'd0, ovf: 1'b0};
`else
        e = '{val: 32'h80000000, idx: 2'd3, cnt: 3'd0, ovf: 1'b0};
`endif
        run_frame(32'hC0000000, 32'hBF800000, 32'hC0400000, 32'h80000000, 4'b0000, e, 0, 0);

        // Overflow on beat 2 with a long downstream stall.
        e = '{val: 32'h40400000, idx: 2'd1, cnt: 3'd4, ovf: 1'b1};
        run_frame(32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000, 4'b0100, e, 0, 5);

        // Partial frame aborted by reset with a simultaneous beat.
        send_beat(32'h7F000000, 1'b1);
        send_beat(32'h7F100000, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h7F200000; in_ovf = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_max_val", max_val, 32'd0);
        chk("abort_max_idx", 32'(max_idx), 32'd0);
        chk("abort_active_cnt", 32'(active_cnt), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_ovf = 1'b0;
        e = '{val: 32'h40400000, idx: 2'd1, cnt: 3'd4, ovf: 1'b0};
        run_frame(32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000, 4'b0000, e, 0, 1);

        // Same frame with idle gaps between beats.
        run_frame(32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000, 4'b0000, e, 3, 0);

        // Infinity beats the largest finite value.
        e = '{val: 32'h7F800000, idx: 2'd1, cnt: 3'd3, ovf: 1'b0};
        run_frame(32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h00000000, 4'b0000, e, 0, 0);

        // +0 / -0 ties keep the earliest index.
        e = '{val: 32'h00000000, idx: 2'd0, cnt: 3'd0, ovf: 1'b0};
        run_frame(32'h00000000, 32'h80000000, 32'hBF800000, 32'h00000000, 4'b0000, e, 0, 0);

        // Mixed signs with a later equal positive value.
        e = '{val: 32'h3F000000, idx: 2'd1, cnt: 3'd2, ovf: 1'b1};
        run_frame(32'hBF800000, 32'h3F000000, 32'h80000000, 32'h3F000000, 4'b1000, e, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_max_tracker.md
FP_MAX_TRACKER -- requirements
Module: fp_max_tracker

Interface
REQ-001 Parameter N, default 4: number of single-precision values per frame, legal range 2..256.
REQ-002 Parameter IW, default 2: index width, equal to ceil(log2(N)).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  32  IEEE-754 single product from the upstream multiplier.
REQ-006 in_ovf  input  1  upstream overflow flag, qualified by in_valid.
REQ-007 in_valid  input  1  in_data/in_ovf valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 max_val  output  32  largest value of the frame.
REQ-010 max_idx  output  IW  frame position (0-based) of max_val.
REQ-011 active_cnt  output  IW+1  count of beats in the frame with sign=0 and bits[30:0] nonzero.
REQ-012 ovf  output  1  OR of in_ovf over all beats of the frame.
REQ-013 out_valid  output  1  result outputs valid.
REQ-014 out_ready  input  1  downstream accepts the result.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACC and HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; a beat is accepted when in_valid and in_ready are both 1.
REQ-017 The first accepted beat SHALL be taken in IDLE: it loads max_val, sets max_idx=0, loads ovf=in_ovf and initialises active_cnt from that beat, sets beat count to 1, then moves to ACC.
REQ-018 Each beat accepted in ACC SHALL update the running max, active_cnt, the OR of ovf, and the beat count.
REQ-019 When the N-th beat is accepted, the FSM SHALL move to HOLD and set out_valid=1 in the next cycle, giving 1 cycle latency from the last beat.
REQ-020 In HOLD, all outputs SHALL stay stable until out_ready=1; on out_valid and out_ready both 1, the FSM SHALL move to IDLE with out_valid=0 in the next cycle.
REQ-021 Comparison rules:
- Both signs 0: the larger bits[30:0] wins.
- Both signs 1: the smaller bits[30:0] wins.
- Signs differ: the positive value wins.
- +0 and -0 compare equal.
REQ-022 On a tie, the stored max and index SHALL be kept, so the earliest index wins.
REQ-023 Infinities SHALL compare by the same bit rules; NaN inputs SHALL be treated as their raw bit patterns, with no special handling.
REQ-024 in_valid=0 in IDLE or ACC SHALL leave all state unchanged; there is no timeout.
REQ-025 active_cnt SHALL saturate at N and never wrap.

Reset
REQ-026 When rst=1 at a clock edge, the FSM SHALL go to IDLE and SHALL clear max_val, max_idx, active_cnt, ovf, out_valid and the beat count to 0.
REQ-027 Reset SHALL take priority over any simultaneous handshake, and a partial frame SHALL be discarded.
REQ-028 In the cycle after reset is released, in_ready SHALL be 1.

Configuration
REQ-029 With macro FP_MAX_TRACKER_RELU_EN defined, every accepted beat with sign=1 SHALL be replaced by +0 before comparison, and ovf accumulation SHALL be unaffected.
REQ-030 With FP_MAX_TRACKER_RELU_EN undefined, values SHALL be compared signed per REQ-021.

Verification
REQ-031 N=4, beats 0x3F800000, 0x40400000, 0x40000000, 0x3F000000 -> max_val=0x40400000, max_idx=1, active_cnt=4, ovf=0, out_valid 1 cycle after the 4th beat.
REQ-032 N=4, beats 0xC0000000, 0xBF800000, 0xC0400000, 0x80000000, RELU_EN undefined -> max_val=0x80000000, max_idx=3, active_cnt=0.
REQ-033 Same stimulus as REQ-032 with RELU_EN defined -> max_val=0x00000000, max_idx=0 (tie keeps earliest), active_cnt=0.
REQ-034 Frame from REQ-031 with in_ovf=1 on beat 2, out_ready held 0 for 5 cycles -> ovf=1, outputs stable, in_ready=0 throughout HOLD; then out_ready=1 -> IDLE next cycle.
REQ-035 Two beats accepted, then rst=1 together with in_valid=1 -> all outputs 0, IDLE; the next full frame gives a correct result with no carry-over.
REQ-036 Gaps with in_valid=0 between beats of the REQ-031 frame -> identical result; beats 0x7F800000 and 0x7F7FFFFF -> the infinity wins.
